// File: rtl/stream_magnitude_comparator_if.sv
// Word-serial operand/result handshake bundle for the stream magnitude comparator.
// The comparator sits on the slave side; whoever feeds operands and drains flags is the master.
interface stream_magnitude_comparator_if #(
    parameter int WORD_W    = 4,
    parameter int NUM_WORDS = 4
);
    logic              In_Valid;
    logic              In_Ready;
    logic [WORD_W-1:0] In1;
    logic [WORD_W-1:0] In2;
    logic              Signed_Mode;
    logic              Out_Valid;
    logic              Out_Ready;
    logic              Greater;
    logic              Lesser;
    logic              Equal;

    modport master (
        output In_Valid, In1, In2, Signed_Mode, Out_Ready,
        input  In_Ready, Out_Valid, Greater, Lesser, Equal
    );

    modport slave (
        input  In_Valid, In1, In2, Signed_Mode, Out_Ready,
        output In_Ready, Out_Valid, Greater, Lesser, Equal
    );
endinterface

// File: rtl/stream_magnitude_comparator.sv
// Compares two multi-word operands streamed most-significant word first.
// The first differing word decides the verdict; the result is held until the consumer takes it.
module stream_magnitude_comparator #(
    parameter int WORD_W    = 4,
    parameter int NUM_WORDS = 4
) (
    input logic                          clk,
    input logic                          rst,
    stream_magnitude_comparator_if.slave bus
);
    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] word_cnt;
    logic             decided;
    logic [1:0]       verdict;
    logic             greater_q;
    logic             lesser_q;
    logic             equal_q;

    logic             accept;
    logic             release_result;
    logic             first_word;
    logic             last_word;
    logic             word_ne;
    logic             word_gt;
    logic [1:0]       final_verdict;

    // verdict encoding is {GT, LT}; 2'b00 means no word has differed yet.
    // Only the most-significant word carries the sign, so signedness matters there alone.
    always_comb begin
        accept         = (state == ACCUM) && bus.In_Valid;
        release_result = (state == HOLD) && bus.Out_Ready;
        first_word     = (word_cnt == '0);
        last_word      = (word_cnt == LAST_CNT);
        word_ne        = (bus.In1 != bus.In2);
        if (first_word && bus.Signed_Mode) begin
            word_gt = ($signed(bus.In1) > $signed(bus.In2));
        end else begin
            word_gt = (bus.In1 > bus.In2);
        end
        if (decided) begin
            final_verdict = verdict;
        end else if (word_ne) begin
            final_verdict = word_gt ? 2'b10 : 2'b01;
        end else begin
            final_verdict = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (accept && last_word) state_next = HOLD;
            HOLD:  if (release_result) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // The last word commits the verdict into the output flags and clears the
    // tracking state, so the next pair starts fresh even before the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt  <= '0;
            decided   <= 1'b0;
            verdict   <= 2'b00;
            greater_q <= 1'b0;
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
        end else if (release_result) begin
            word_cnt  <= '0;
            decided   <= 1'b0;
            verdict   <= 2'b00;
            greater_q <= 1'b0;
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
        end else if (accept) begin
            if (last_word) begin
                word_cnt  <= '0;
                decided   <= 1'b0;
                verdict   <= 2'b00;
                greater_q <= final_verdict[1];
                lesser_q  <= final_verdict[0];
                equal_q   <= (final_verdict == 2'b00);
            end else begin
                word_cnt <= word_cnt + CNT_W'(1);
                decided  <= decided | word_ne;
                verdict  <= final_verdict;
            end
        end
    end

    assign bus.In_Ready  = (state == ACCUM);
    assign bus.Out_Valid = (state == HOLD);
    assign bus.Greater   = greater_q;
    assign bus.Lesser    = lesser_q;
    assign bus.Equal     = equal_q;
endmodule

// File: tb/tb_stream_magnitude_comparator.sv
// Randomized bench for stream_magnitude_comparator: a whole-operand reference model
// predicts handshake state and flags every cycle, with directed pairs pinning known results.
module tb_stream_magnitude_comparator;
    localparam int W   = 4;
    localparam int N   = 4;
    localparam int TOT = W * N;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stream_magnitude_comparator_if #(.WORD_W(W), .NUM_WORDS(N)) bus ();

    stream_magnitude_comparator #(.WORD_W(W), .NUM_WORDS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: gathers whole operands and compares them as plain integers.
    logic [TOT-1:0]        acc_a;
    logic [TOT-1:0]        acc_b;
    logic signed [TOT-1:0] sa;
    logic signed [TOT-1:0] sb;
    int                    wcnt;
    bit                    sm0;
    bit                    exp_hold;
    bit                    exp_g;
    bit                    exp_l;
    bit                    exp_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt     = 0;
            exp_hold = 1'b0;
            exp_g    = 1'b0;
            exp_l    = 1'b0;
            exp_e    = 1'b0;
        end else if (!exp_hold && bus.In_Valid) begin
            if (wcnt == 0) sm0 = bus.Signed_Mode;
            acc_a = {acc_a[TOT-W-1:0], bus.In1};
            acc_b = {acc_b[TOT-W-1:0], bus.In2};
            wcnt++;
            if (wcnt == N) begin
                wcnt = 0;
                sa   = acc_a;
                sb   = acc_b;
                if (sm0) begin
                    exp_g = (sa > sb);
                    exp_l = (sa < sb);
                end else begin
                    exp_g = (acc_a > acc_b);
                    exp_l = (acc_a < acc_b);
                end
                exp_e    = (acc_a == acc_b);
                exp_hold = 1'b1;
            end
        end else if (exp_hold && bus.Out_Ready) begin
            exp_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready",  bus.In_Ready,  !exp_hold);
            check("out_valid", bus.Out_Valid, exp_hold);
            check("greater",   bus.Greater,   exp_hold && exp_g);
            check("lesser",    bus.Lesser,    exp_hold && exp_l);
            check("equal",     bus.Equal,     exp_hold && exp_e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one operand pair; caller guarantees the DUT is collecting words.
    task automatic applyStimulus(input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                                 input bit sm, input bit sm_later, input int max_gap);
        for (int i = 0; i < N; i++) begin
            bus.In_Valid    = 1'b1;
            bus.In1         = a[TOT-1-i*W -: W];
            bus.In2         = b[TOT-1-i*W -: W];
            bus.Signed_Mode = (i == 0) ? sm : sm_later;
            tick();
            bus.In_Valid    = 1'b0;
            bus.In1         = W'($urandom);
            bus.In2         = W'($urandom);
            bus.Signed_Mode = 1'($urandom);
            if (i < N - 1) begin
                repeat ($urandom_range(0, max_gap)) tick();
            end
        end
    endtask

    task automatic checkOutput(string name, bit g, bit l, bit e);
        int k;
        k = 0;
        while (!bus.Out_Valid && k < 20) begin
            tick();
            k++;
        end
        check({name, "_valid"},   bus.Out_Valid, 1'b1);
        check({name, "_greater"}, bus.Greater,   g);
        check({name, "_lesser"},  bus.Lesser,    l);
        check({name, "_equal"},   bus.Equal,     e);
        check({name, "_model"},   {exp_g, exp_l, exp_e}, {g, l, e});
    endtask

    // Drains any held result while throwing garbage words that must be ignored.
    task automatic waitIdle(input bit rand_ready);
        for (int k = 0; k < 200; k++) begin
            if (!bus.Out_Valid) begin
                bus.In_Valid = 1'b0;
                return;
            end
            bus.Out_Ready = rand_ready ? 1'($urandom) : 1'b1;
            bus.In_Valid  = 1'($urandom);
            bus.In1       = W'($urandom);
            bus.In2       = W'($urandom);
            tick();
        end
        check("wait_idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic pulseReset();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", bus.Out_Valid, 1'b0);
        check("async_rst_in_ready",  bus.In_Ready,  1'b1);
        check("async_rst_flags",     {bus.Greater, bus.Lesser, bus.Equal}, 3'b000);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [TOT-1:0] a;
        logic [TOT-1:0] b;
        checks = 0;
        errors = 0;
        rst             = 1'b1;
        bus.In_Valid    = 1'b0;
        bus.In1         = '0;
        bus.In2         = '0;
        bus.Signed_Mode = 1'b0;
        bus.Out_Ready   = 1'b0;
        repeat (3) tick();
        check("reset_in_ready",  bus.In_Ready,  1'b1);
        check("reset_out_valid", bus.Out_Valid, 1'b0);
        check("reset_flags",     {bus.Greater, bus.Lesser, bus.Equal}, 3'b000);
        rst = 1'b0;
        tick();

        $display("[TB] directed pairs");
        bus.Out_Ready = 1'b1;
        applyStimulus(16'h1234, 16'h1235, 1'b0, 1'b0, 0);
        check("lat_out_valid", bus.Out_Valid, 1'b1);
        checkOutput("unsigned_lt", 1'b0, 1'b1, 1'b0);
        waitIdle(1'b0);

        applyStimulus(16'h8000, 16'h7FFF, 1'b1, 1'b1, 0);
        checkOutput("signed_lt", 1'b0, 1'b1, 1'b0);
        waitIdle(1'b0);
        applyStimulus(16'h8000, 16'h7FFF, 1'b0, 1'b0, 0);
        checkOutput("unsigned_gt", 1'b1, 1'b0, 1'b0);
        waitIdle(1'b0);
        applyStimulus(16'h8000, 16'h7FFF, 1'b1, 1'b0, 0);
        checkOutput("signed_latched", 1'b0, 1'b1, 1'b0);
        waitIdle(1'b0);

        applyStimulus(16'hABCD, 16'hABCD, 1'b0, 1'b0, 3);
        checkOutput("gapped_equal", 1'b0, 1'b0, 1'b1);
        waitIdle(1'b0);

        bus.Out_Ready = 1'b0;
        applyStimulus(16'h9000, 16'h1FFF, 1'b0, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            bus.In_Valid = 1'b1;
            bus.In1      = W'($urandom);
            bus.In2      = W'($urandom);
            tick();
            check("hold_stable", {bus.Out_Valid, bus.In_Ready, bus.Greater, bus.Lesser, bus.Equal},
                  5'b10100);
        end
        bus.In_Valid  = 1'b0;
        bus.Out_Ready = 1'b1;
        tick();
        check("hold_release", {bus.Out_Valid, bus.In_Ready}, 2'b01);

        bus.In_Valid = 1'b1;
        bus.In1      = 4'h5;
        bus.In2      = 4'h2;
        tick();
        bus.In1 = 4'h3;
        bus.In2 = 4'h3;
        tick();
        bus.In_Valid = 1'b0;
        pulseReset();
        applyStimulus(16'h0001, 16'h0000, 1'b0, 1'b0, 0);
        checkOutput("post_reset_gt", 1'b1, 1'b0, 1'b0);
        waitIdle(1'b0);

        bus.Out_Ready = 1'b0;
        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, 0);
        checkOutput("pre_hold_reset", 1'b0, 1'b1, 1'b0);
        pulseReset();
        bus.Out_Ready = 1'b1;
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        checkOutput("signed_neg_one", 1'b0, 1'b1, 1'b0);
        waitIdle(1'b0);

        $display("[TB] random pairs");
        for (int p = 0; p < 150; p++) begin
            a = TOT'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {a[TOT-1:W], W'($urandom)};
                2: b = a ^ (TOT'(1) << $urandom_range(0, TOT - 1));
                default: b = TOT'($urandom);
            endcase
            waitIdle(1'b1);
            applyStimulus(a, b, 1'($urandom), 1'($urandom), 2);
        end
        waitIdle(1'b1);
        tick();

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/stream_magnitude_comparator.md
STREAM_MAGNITUDE_COMPARATOR -- requirements
Module: stream_magnitude_comparator

Interface
REQ-001 Parameter WORD_W, default 4, width in bits of one operand word per beat; SHALL be >= 2.
REQ-002 Parameter NUM_WORDS, default 4, words per operand; full operand width = WORD_W*NUM_WORDS; SHALL be >= 1.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 In_Valid  input  1  In1/In2/Signed_Mode carry a valid word this cycle.
REQ-007 In_Ready  output  1  block accepts a word this cycle.
REQ-008 In1  input  WORD_W  operand A word, most-significant word first.
REQ-009 In2  input  WORD_W  operand B word, most-significant word first.
REQ-010 Signed_Mode  input  1  1 = two's-complement compare; sampled only on the first word of an operand pair.
REQ-011 Out_Valid  output  1  result flags valid.
REQ-012 Out_Ready  input  1  consumer accepts result.
REQ-013 Greater  output  1  A > B.
REQ-014 Lesser  output  1  A < B.
REQ-015 Equal  output  1  A == B.

Function
REQ-016 FSM SHALL have two states: ACCUM (collecting words) and HOLD (presenting result).
REQ-017 In ACCUM, In_Ready SHALL be 1 and Out_Valid 0; in HOLD, In_Ready SHALL be 0 and Out_Valid 1.
REQ-018 A word SHALL be accepted only on a rising edge with In_Valid=1 and In_Ready=1; In_Valid while In_Ready=0 has no effect.
REQ-019 Internal word counter SHALL run 0..NUM_WORDS-1, increment on each accepted word, and wrap to 0 on the last.
REQ-020 Internal decided flag and a 2-bit verdict (GT/LT) SHALL be cleared at the start of every operand pair.
REQ-021 On the first word (count 0), words SHALL be compared signed (WORD_W-bit two's complement) if Signed_Mode=1, otherwise unsigned; Signed_Mode SHALL be latched then and ignored on later words.
REQ-022 On words with count > 0, words SHALL be compared unsigned.
REQ-023 While undecided, an accepted word pair with In1 != In2 SHALL set decided and record GT or LT; equal words leave it undecided.
REQ-024 Once decided, later words of the same pair SHALL still be accepted and counted but SHALL NOT change the verdict.
REQ-025 On acceptance of word NUM_WORDS-1, the FSM SHALL enter HOLD on that same edge; Out_Valid and flags SHALL be asserted from the next cycle (1-cycle latency from last accepted word).
REQ-026 In HOLD, exactly one of Greater/Lesser/Equal SHALL be 1; Equal=1 iff the pair never became decided; flags SHALL be registered and stable until handshake.
REQ-027 In ACCUM, Greater, Lesser and Equal SHALL all be 0.
REQ-028 In HOLD, Out_Valid=1 with Out_Ready=1 on a rising edge SHALL return to ACCUM, clearing counter, decided and verdict; In_Ready becomes 1 the following cycle (no same-cycle pass-through).
REQ-029 Out_Ready while in ACCUM SHALL have no effect.
REQ-030 NUM_WORDS=1 SHALL behave as a single-word comparator with the same handshake and latency.

Reset
REQ-031 rst=1 SHALL immediately, independent of clk, force state ACCUM, counter 0, decided 0, verdict cleared, latched sign mode 0.
REQ-032 During reset: In_Ready=1 after rst deasserts, Out_Valid=0, Greater=0, Lesser=0, Equal=0.
REQ-033 Reset mid-operand or in HOLD SHALL discard all partial words and any pending result; the next accepted word is treated as word 0.

Verification (WORD_W=4, NUM_WORDS=4)
REQ-034 Unsigned A=0x1234, B=0x1235, Out_Ready=1 -> after 4th accepted word, next cycle Out_Valid=1, Lesser=1, then ACCUM.
REQ-035 Signed A=0x8000, B=0x7FFF -> Lesser=1; same operands with Signed_Mode=0 -> Greater=1; Signed_Mode toggled to 0 on words 1..3 of the signed run -> result unchanged.
REQ-036 A=B=0xABCD with In_Valid gapped (idle cycles between words) -> Equal=1 only after 4th word; no flags before.
REQ-037 A=0x9000, B=0x1FFF unsigned (decided on word 0), Out_Ready=0 for 5 cycles -> Greater=1 and Out_Valid held stable, In_Ready=0, extra In_Valid ignored; Out_Ready=1 -> ACCUM.
REQ-038 Assert rst after 2 words of a pair, then send a full pair A=0x0001, B=0x0000 -> Greater=1; no residue from aborted pair.
